// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares one D-cache CPU port between the load/store unit (M0)
// and a debug/DMA master (M1). Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
`default_nettype none

module dcache_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                M0_REQ,
    input  logic                M0_WE,
    input  logic [ADDR_W-1:0]   M0_ADDR,
    input  logic [DATA_W-1:0]   M0_WDATA,
    input  logic [DATA_W/8-1:0] M0_WSTRB,
    output logic                M0_ACK,
    output logic [DATA_W-1:0]   M0_RDATA,
    input  logic                M1_REQ,
    input  logic                M1_WE,
    input  logic [ADDR_W-1:0]   M1_ADDR,
    input  logic [DATA_W-1:0]   M1_WDATA,
    input  logic [DATA_W/8-1:0] M1_WSTRB,
    output logic                M1_ACK,
    output logic [DATA_W-1:0]   M1_RDATA,
    output logic                CPU_REQ,
    output logic [ADDR_W-1:0]   CPU_REQ_ADDR,
    input  logic                CPU_REQ_VALID,
    input  logic [DATA_W-1:0]   CPU_REQ_DATA,
    output logic                CPU_WR_EN,
    output logic [DATA_W-1:0]   CPU_WR_DATA,
    output logic [DATA_W/8-1:0] CPU_WR_STRB,
    input  logic                BUSY,
    output logic                GNT_ID
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_WR_ISSUE = 3'd2,
        ST_WR_BUSY  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                cpu_req_q, cpu_req_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                win_id;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_q;

    // Pointer moves to the requester that did not win the transaction just finished.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            prio_q <= 1'b0;
        end else if (state_q == ST_RESP) begin
            prio_q <= ~gnt_q;
        end
    end

    assign win_id = (M0_REQ && M1_REQ) ? prio_q : ~M0_REQ;
`else
    assign win_id = ~M0_REQ;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cpu_req_d = cpu_req_q;
        wr_en_d   = wr_en_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (M0_REQ || M1_REQ) begin
                    gnt_d  = win_id;
                    addr_d = win_id ? M1_ADDR : M0_ADDR;
                    if (win_id ? M1_WE : M0_WE) begin
                        wdata_d = win_id ? M1_WDATA : M0_WDATA;
                        wstrb_d = win_id ? M1_WSTRB : M0_WSTRB;
                        wr_en_d = 1'b1;
                        state_d = ST_WR_ISSUE;
                    end else begin
                        cpu_req_d = 1'b1;
                        state_d   = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (CPU_REQ_VALID) begin
                    cpu_req_d = 1'b0;
                    if (gnt_q) begin
                        rdata1_d = CPU_REQ_DATA;
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = CPU_REQ_DATA;
                        ack0_d   = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_WR_ISSUE: begin
                if (BUSY) begin
                    state_d = ST_WR_BUSY;
                end
            end
            ST_WR_BUSY: begin
                if (!BUSY) begin
                    wr_en_d = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cpu_req_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cpu_req_q <= cpu_req_d;
            wr_en_q   <= wr_en_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
        end
    end

    assign M0_ACK       = ack0_q;
    assign M1_ACK       = ack1_q;
    assign M0_RDATA     = rdata0_q;
    assign M1_RDATA     = rdata1_q;
    assign CPU_REQ      = cpu_req_q;
    assign CPU_REQ_ADDR = addr_q;
    assign CPU_WR_EN    = wr_en_q;
    assign CPU_WR_DATA  = wdata_q;
    assign CPU_WR_STRB  = wstrb_q;
    assign GNT_ID       = gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed self-checking bench with a small cache responder model.
`default_nettype none

module tb_dcache_port_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        M0_REQ, M0_WE, M1_REQ, M1_WE;
    logic [31:0] M0_ADDR, M0_WDATA, M1_ADDR, M1_WDATA;
    logic [3:0]  M0_WSTRB, M1_WSTRB;
    logic        M0_ACK, M1_ACK;
    logic [31:0] M0_RDATA, M1_RDATA;
    logic        CPU_REQ, CPU_REQ_VALID, CPU_WR_EN, BUSY, GNT_ID;
    logic [31:0] CPU_REQ_ADDR, CPU_REQ_DATA, CPU_WR_DATA;
    logic [3:0]  CPU_WR_STRB;

    int n_chk = 0;
    int n_fail = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;

    // cache model controls
    bit          resp_en = 1'b1;
    int          busy_len = 3;
    logic        man_valid = 1'b0;
    logic [31:0] man_data = '0;

    // observations gathered by serve()
    int          order[$];
    int          wr_cyc, rd_cyc, ack_cyc0, ack_cyc1;
    logic [31:0] cap_wdata, cap_waddr, cap_raddr;
    logic [3:0]  cap_wstrb;

    dcache_port_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_WSTRB(M0_WSTRB), .M0_ACK(M0_ACK), .M0_RDATA(M0_RDATA),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_WSTRB(M1_WSTRB), .M1_ACK(M1_ACK), .M1_RDATA(M1_RDATA),
        .CPU_REQ(CPU_REQ), .CPU_REQ_ADDR(CPU_REQ_ADDR), .CPU_REQ_VALID(CPU_REQ_VALID),
        .CPU_REQ_DATA(CPU_REQ_DATA), .CPU_WR_EN(CPU_WR_EN), .CPU_WR_DATA(CPU_WR_DATA),
        .CPU_WR_STRB(CPU_WR_STRB), .BUSY(BUSY), .GNT_ID(GNT_ID)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (M0_ACK) ack0_cnt++;
        if (M1_ACK) ack1_cnt++;
    end

    // Cache responder: read data after 2 cycles of CPU_REQ, BUSY for busy_len cycles per write.
    initial begin : cache_model
        logic [31:0] mem [16];
        int rcnt = 0;
        int wcnt = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA5A50000 + i;
        BUSY = 1'b0;
        CPU_REQ_VALID = 1'b0;
        CPU_REQ_DATA = '0;
        forever begin
            @(posedge ACLK);
            #2;
            if (!resp_en) begin
                rcnt = 0;
                wcnt = 0;
                BUSY = 1'b0;
                CPU_REQ_VALID = man_valid;
                CPU_REQ_DATA = man_data;
            end else begin
                CPU_REQ_VALID = 1'b0;
                if (CPU_REQ) begin
                    rcnt++;
                    if (rcnt == 2) begin
                        CPU_REQ_VALID = 1'b1;
                        CPU_REQ_DATA = mem[CPU_REQ_ADDR[5:2]];
                        rcnt = 0;
                    end
                end else begin
                    rcnt = 0;
                end
                if (CPU_WR_EN) begin
                    wcnt++;
                    if (wcnt == 1) begin
                        BUSY = 1'b1;
                        for (int b = 0; b < 4; b++)
                            if (CPU_WR_STRB[b]) mem[CPU_REQ_ADDR[5:2]][8*b +: 8] = CPU_WR_DATA[8*b +: 8];
                    end else if (wcnt == 1 + busy_len) begin
                        BUSY = 1'b0;
                    end
                end else begin
                    wcnt = 0;
                    BUSY = 1'b0;
                end
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Runs already-raised requests until n acknowledges; hold=0 drops each REQ the cycle after its ACK.
    task automatic serve(input int n, input bit hold);
        int  got = 0;
        int  cyc = 0;
        bit  drop0 = 1'b0;
        bit  drop1 = 1'b0;
        bit  seen_wr = 1'b0;
        order.delete();
        wr_cyc = 0;
        rd_cyc = 0;
        ack_cyc0 = -1;
        ack_cyc1 = -1;
        while (got < n && cyc < 200) begin
            tick();
            cyc++;
            if (drop0) begin M0_REQ = 1'b0; drop0 = 1'b0; end
            if (drop1) begin M1_REQ = 1'b0; drop1 = 1'b0; end
            if (CPU_WR_EN) begin
                wr_cyc++;
                if (!seen_wr) begin
                    cap_wdata = CPU_WR_DATA;
                    cap_wstrb = CPU_WR_STRB;
                    cap_waddr = CPU_REQ_ADDR;
                    seen_wr = 1'b1;
                end
            end
            if (CPU_REQ) begin
                rd_cyc++;
                cap_raddr = CPU_REQ_ADDR;
            end
            if (M0_ACK || M1_ACK) begin
                order.push_back(int'(GNT_ID));
                got++;
            end
            if (M0_ACK) begin ack_cyc0 = cyc; if (!hold) drop0 = 1'b1; end
            if (M1_ACK) begin ack_cyc1 = cyc; if (!hold) drop1 = 1'b1; end
        end
        chk_eq("serve_done", got, n);
        tick();
        M0_REQ = 1'b0;
        M1_REQ = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int a0, a1;
        logic [3:0] pat;
        ARESETn = 1'b0;
        M0_REQ = 0; M0_WE = 0; M0_ADDR = '0; M0_WDATA = '0; M0_WSTRB = '0;
        M1_REQ = 0; M1_WE = 0; M1_ADDR = '0; M1_WDATA = '0; M1_WSTRB = '0;
        repeat (3) tick();
        chk_eq("rst_cpu_req", CPU_REQ, 0);
        chk_eq("rst_wr_en", CPU_WR_EN, 0);
        chk_eq("rst_acks", {M0_ACK, M1_ACK}, 0);
        chk_eq("rst_gnt", GNT_ID, 0);
        chk_eq("rst_rdata", {M0_RDATA, M1_RDATA}, 0);
        ARESETn = 1'b1;
        repeat (2) tick();

        // M0 write, BUSY high for 3 cycles
        a0 = ack0_cnt; a1 = ack1_cnt;
        M0_WE = 1; M0_ADDR = 32'h10; M0_WDATA = 32'hDEADBEEF; M0_WSTRB = 4'hF; M0_REQ = 1;
        serve(1, 0);
        chk_eq("wr_ack0", ack0_cnt - a0, 1);
        chk_eq("wr_ack1", ack1_cnt - a1, 0);
        chk_eq("wr_gnt", order[0], 0);
        chk_eq("wr_en_cycles", wr_cyc, 4);
        chk_eq("wr_ack_latency", ack_cyc0, 5);
        chk_eq("wr_data", cap_wdata, 32'hDEADBEEF);
        chk_eq("wr_strb", cap_wstrb, 4'hF);
        chk_eq("wr_addr", cap_waddr, 32'h10);
        chk_eq("wr_data_cleared", {CPU_WR_DATA, CPU_WR_STRB, CPU_WR_EN}, 0);

        // M1 read of the location just written
        a0 = ack0_cnt; a1 = ack1_cnt;
        M1_WE = 0; M1_ADDR = 32'h10; M1_REQ = 1;
        serve(1, 0);
        chk_eq("rd_ack1", ack1_cnt - a1, 1);
        chk_eq("rd_ack0", ack0_cnt - a0, 0);
        chk_eq("rd_gnt", order[0], 1);
        chk_eq("rd_req_cycles", rd_cyc, 2);
        chk_eq("rd_ack_latency", ack_cyc1, 3);
        chk_eq("rd_addr", cap_raddr, 32'h10);
        chk_eq("rd_data", M1_RDATA, 32'hDEADBEEF);
        chk_eq("rd_req_dropped", CPU_REQ, 0);

        // simultaneous reads: M0 first, M1 one IDLE cycle later
        M0_WE = 0; M0_ADDR = 32'h0; M1_WE = 0; M1_ADDR = 32'h4;
        M0_REQ = 1; M1_REQ = 1;
        serve(2, 0);
        chk_eq("sim_order", {order[0][0], order[1][0]}, 2'b01);
        chk_eq("sim_gap", ack_cyc1 - ack_cyc0, 4);
        chk_eq("sim_rdata0", M0_RDATA, 32'hA5A50000);
        chk_eq("sim_rdata1", M1_RDATA, 32'hA5A50001);

        // both held for 4 transactions
        M0_REQ = 1; M1_REQ = 1;
        serve(4, 1);
        pat = {order[0][0], order[1][0], order[2][0], order[3][0]};
`ifdef ARB_ROUND_ROBIN_EN
        chk_eq("held_grant_seq", pat, 4'b0101);
`else
        chk_eq("held_grant_seq", pat, 4'b0000);
`endif

        // reset during WR_BUSY
        busy_len = 20;
        M0_WE = 1; M0_ADDR = 32'h20; M0_WDATA = 32'h12345678; M0_WSTRB = 4'hF; M0_REQ = 1;
        repeat (4) tick();
        chk_eq("mid_wr_en", CPU_WR_EN, 1);
        a0 = ack0_cnt; a1 = ack1_cnt;
        ARESETn = 1'b0;
        #1;
        chk_eq("arst_wr_en", CPU_WR_EN, 0);
        chk_eq("arst_cpu_req", CPU_REQ, 0);
        chk_eq("arst_acks", {M0_ACK, M1_ACK}, 0);
        chk_eq("arst_rdata0", M0_RDATA, 0);
        M0_REQ = 0;
        repeat (2) tick();
        ARESETn = 1'b1;
        busy_len = 3;
        repeat (2) tick();
        chk_eq("arst_no_ack", (ack0_cnt - a0) + (ack1_cnt - a1), 0);
        M1_WE = 0; M1_ADDR = 32'h4; M1_REQ = 1;
        a1 = ack1_cnt;
        serve(1, 0);
        chk_eq("post_rst_ack1", ack1_cnt - a1, 1);
        chk_eq("post_rst_rdata1", M1_RDATA, 32'hA5A50001);

        // stray CPU_REQ_VALID while idle
        resp_en = 1'b0;
        tick();
        a0 = ack0_cnt; a1 = ack1_cnt;
        man_data = 32'hFFFFFFFF;
        man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        repeat (3) tick();
        chk_eq("stray_no_ack", (ack0_cnt - a0) + (ack1_cnt - a1), 0);
        chk_eq("stray_rdata1", M1_RDATA, 32'hA5A50001);
        chk_eq("stray_rdata0", M0_RDATA, 0);
        chk_eq("stray_cpu_req", CPU_REQ, 0);
        resp_en = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single D-cache CPU port (CPU_REQ / CPU_WR_EN / BUSY protocol) between two requesters.
- Requester 0 is the core load/store unit; requester 1 is a debug/DMA master.
- Arbitrates, drives one transaction at a time onto the cache port, tracks read and write completion, and returns a one-cycle acknowledge plus read data to the winner.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 32, address width.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- M0_REQ  in  1  requester 0 request; level, held until M0_ACK.
- M0_WE  in  1  1 = write, 0 = read.
- M0_ADDR  in  ADDR_W  byte address.
- M0_WDATA  in  DATA_W  write data.
- M0_WSTRB  in  DATA_W/8  byte strobes.
- M0_ACK  out  1  one-cycle completion pulse.
- M0_RDATA  out  DATA_W  read data; valid when M0_ACK=1.
- M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_WSTRB, M1_ACK, M1_RDATA: same as the M0 set, for requester 1.
- CPU_REQ  out  1  cache read request.
- CPU_REQ_ADDR  out  ADDR_W  cache address.
- CPU_REQ_VALID  in  1  cache read data valid.
- CPU_REQ_DATA  in  DATA_W  cache read data.
- CPU_WR_EN  out  1  cache write enable.
- CPU_WR_DATA  out  DATA_W  cache write data.
- CPU_WR_STRB  out  DATA_W/8  cache write strobes.
- BUSY  in  1  cache busy (write in progress / refill).
- GNT_ID  out  1  owner of the current transaction; valid when state != IDLE.

Behaviour:
- Reset values (async, ARESETn=0): all outputs 0, state IDLE, priority pointer = M0.
- States:
  - IDLE: no transaction in flight.
  - RD_WAIT: read issued, waiting for CPU_REQ_VALID.
  - WR_ISSUE: write issued, waiting for BUSY to rise.
  - WR_BUSY: waiting for BUSY to fall.
  - RESP: acknowledge cycle.
- IDLE:
  - Select a winner among asserted Mx_REQ.
  - Latch its ADDR/WE/WDATA/WSTRB and set GNT_ID.
  - Next state is RD_WAIT if WE=0, else WR_ISSUE.
  - Cache outputs are registered; CPU_REQ or CPU_WR_EN rises the cycle after the request is sampled.
- RD_WAIT:
  - CPU_REQ=1, address held.
  - On CPU_REQ_VALID=1: capture CPU_REQ_DATA into the winner's RDATA, drop CPU_REQ, go to RESP.
  - BUSY is ignored in this state.
- WR_ISSUE:
  - CPU_WR_EN=1 with data, strobe and address held.
  - On BUSY=1, go to WR_BUSY.
- WR_BUSY:
  - CPU_WR_EN stays 1.
  - On BUSY=0, drop CPU_WR_EN and clear WR_DATA/WR_STRB to 0, go to RESP.
- RESP:
  - Winner's ACK=1 for exactly one cycle; the loser's ACK stays 0.
  - Always returns to IDLE, giving one IDLE cycle between transactions.
- Arbitration:
  - Default is fixed priority, M0 over M1.
  - Simultaneous requests in IDLE: M0 wins; M1 is served on the next IDLE.
- Requester rules:
  - Requesters hold REQ and payload stable until ACK.
  - A requester may drop REQ in the cycle after ACK or hold it for a back-to-back request.
- Mx_RDATA holds its value until that requester's next read completes. Writes leave RDATA unchanged.
- A request deasserted mid-transaction does not abort it; the transaction still completes and ACK is still pulsed.
- Reset mid-transaction: cache outputs drop to 0 immediately. No ACK is issued.
- Protocol error: CPU_REQ_VALID asserted outside RD_WAIT is ignored.
- Throughput: at most one outstanding cache transaction, no pipelining.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: the priority pointer toggles to the non-winner in every RESP cycle. On simultaneous requests the pointed-to requester wins. Back-to-back requests from both masters alternate M0, M1, M0, ...
- Undefined: fixed priority M0 > M1, pointer logic absent. A continuously requesting M0 may starve M1.

Test Plan:
- M0 write addr 0x10, data 0xDEADBEEF, strb 4'b1111; cache BUSY high for 3 cycles -> CPU_WR_EN high from issue until BUSY falls, then M0_ACK pulses once, GNT_ID=0.
- M1 read addr 0x10 after the above -> CPU_REQ=1 with CPU_REQ_ADDR=0x10 until CPU_REQ_VALID; M1_ACK pulses with M1_RDATA=0xDEADBEEF; M0_ACK stays 0.
- M0 and M1 request reads of 0x0 and 0x4 in the same cycle -> M0 served first, M1 served after exactly one IDLE cycle; each gets its own data.
- Both held continuously for 4 transactions -> without macro: M0 served 4 times, M1 0 times; with ARB_ROUND_ROBIN_EN: grants M0, M1, M0, M1.
- ARESETn pulsed low during WR_BUSY -> CPU_WR_EN, CPU_REQ, ACKs = 0 immediately; after release, a new M1 read completes normally.
- CPU_REQ_VALID pulsed while in IDLE -> no ACK, RDATA unchanged.
